multiplier_seq: RTL
===================

// Module: multiplier_seq
// PURPOSE
//  Parametrised sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, radix 2^BPC.
//  Trades area for latency against the combinational array multiplier.
//  Operands and result use valid/ready handshakes, so it drops into datapath pipelines.
//  Optional two's-complement mode.
// PARAMETERS
//  WIDTH  8  operand width in bits; >= 2
//  BPC    1  multiplier bits retired per cycle; must divide WIDTH (1,2,4,... )
//  CYCLES (localparam) = WIDTH/BPC, iterations per operation
// PORTS
//  clk        in   1        single clock, rising edge
//  rst        in   1        asynchronous, active-high reset
//  in_valid   in   1        operands a,b valid
//  in_ready   out  1        block can accept operands (== state IDLE)
//  a          in   WIDTH    multiplicand
//  b          in   WIDTH    multiplier
//  is_signed  in   1        only with MULT_SEQ_SIGNED_EN; sampled with a,b
//  out_valid  out  1        product valid
//  out_ready  in   1        consumer accepts product
//  product    out  2*WIDTH  exact product, no truncation
// BEHAVIOUR
//  Reset:
//  - State is IDLE; out_valid=0; product=0; internal acc/count=0; in_ready=1 once rst drops.
//  - rst asserted mid-operation aborts the operation with no output.
//  FSM IDLE -> BUSY -> DONE -> IDLE:
//  - IDLE: in_valid&&in_ready at edge E0 latches a, b (and sign info), cnt=CYCLES, acc=0, goes to BUSY.
//  - BUSY: each edge adds a*b[BPC-1:0] << (k*BPC) into acc, shifts b right by BPC, and decrements cnt.
//  - The edge with cnt==1 writes product, sets out_valid=1 and goes to DONE.
//  - Latency: out_valid is high after edge E0+CYCLES. Fixed, with no early exit on zero operands.
//  - DONE: product and out_valid are held stable while !out_ready. out_valid&&out_ready -> IDLE, out_valid=0 next edge.
//  - product keeps its last value until the next completion.
//  - in_ready=0 in BUSY and DONE; in_valid is ignored there and operands are never queued.
//  - Minimum initiation interval is CYCLES+2 edges (accept, CYCLES, drain).
//  - A DONE-state out_ready held high completes in 1 cycle; out_ready in IDLE/BUSY is ignored.
//  Width rules:
//  - The accumulator is 2*WIDTH+BPC bits internally; product = acc[2*WIDTH-1:0].
//  - Unsigned max (2^W-1)^2 must fit without overflow.
// CONFIGURATION
//  `define MULT_SEQ_SIGNED_EN:
//  - Adds the is_signed port. With is_signed=1, a and b are two's complement.
//  - Both are magnitude-converted on accept; the result is negated at completion if sign(a)^sign(b).
//  - -2^(W-1) * -2^(W-1) = 2^(2W-2) is exact. Latency is unchanged.
//  Without the macro: port absent, unsigned only, no sign/negate logic synthesised.
// STRUCTURE
//  Package mult_pkg:
//  - state enum {IDLE,BUSY,DONE}.
//  - function clog2-based CNT_W = $clog2(CYCLES+1).
//  - helper localparams for acc width.
//  Sub-module mult_pp_row (combinational):
//  - WIDTH-bit a times BPC-bit slice -> WIDTH+BPC-bit partial row.
//  - Instantiated once and reused each cycle.
//  Top: FSM, counter, b shift reg, acc, output regs.
// TESTING (WIDTH=8, BPC=1 unless noted)
//  1. a=8'd13, b=8'd11, out_ready=1 -> product=16'd143, out_valid exactly 8 cycles after accept, high 1 cycle.
//  2. a=b=8'hFF -> 16'hFE01; a=0,b=8'hAB -> 16'h0000, still after 8 cycles.
//  3. out_ready=0 for 5 cycles after completion -> product/out_valid stable; in_ready=0 and a new in_valid is ignored; accept resumes in IDLE.
//  4. rst pulsed at cycle 4 of BUSY -> out_valid=0, product=0, in_ready=1 after release; the next op (7*9=63) is correct.
//  5. BPC=4, a=8'hA5, b=8'h3C -> 16'h26AC after 2 cycles; random sweep vs a*b reference model for BPC in {1,2,4,8}.
//  6. SIGNED_EN, is_signed=1:
//     - a=8'h80, b=8'h80 -> 16'h4000
//     - a=-3, b=5 -> 16'hFFF1
//     - is_signed=0 with the same bits -> unsigned result

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the sequential shift-add multiplier.
//   state_t : FSM encoding IDLE -> BUSY -> DONE -> IDLE
//   cnt_w   : bits needed to hold the iteration count 0..CYCLES
//   acc_w   : accumulator width; BPC bits of headroom above the 2*WIDTH result
package mult_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  function automatic int cnt_w(input int cycles);
    return $clog2(cycles + 1);
  endfunction

  function automatic int acc_w(input int width, input int bpc);
    return 2 * width + bpc;
  endfunction

endpackage

// File: rtl/mult_pp_row.sv
// Combinational partial-product row: WIDTH-bit multiplicand times one
// BPC-bit slice of the multiplier, giving an exact WIDTH+BPC-bit row.
//   a     : multiplicand
//   slice : low BPC bits of the shifting multiplier
//   row   : a * slice
module mult_pp_row #(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input  logic [WIDTH-1:0]     a,
  input  logic [BPC-1:0]       slice,
  output logic [WIDTH+BPC-1:0] row
);

  assign row = (WIDTH+BPC)'(a) * (WIDTH+BPC)'(slice);

endmodule

// File: rtl/multiplier_seq.sv
// Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, BPC multiplier
// bits retired per cycle (CYCLES = WIDTH/BPC iterations, fixed latency).
// Optional two's-complement mode behind `define MULT_SEQ_SIGNED_EN, which
// adds the is_signed port.
//   clk, rst             : clock, async active-high reset
//   in_valid / in_ready  : operand handshake (in_ready == IDLE)
//   a, b                 : multiplicand, multiplier
//   is_signed            : (MULT_SEQ_SIGNED_EN only) treat a,b as signed
//   out_valid / out_ready: result handshake, product held while stalled
//   product              : exact 2*WIDTH-bit product
module multiplier_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef MULT_SEQ_SIGNED_EN
  input  logic               is_signed,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int CYCLES = WIDTH / BPC;
  localparam int CNT_W  = cnt_w(CYCLES);
  localparam int ACC_W  = acc_w(WIDTH, BPC);
  localparam logic [CNT_W-1:0] CYC_L = CNT_W'(CYCLES);
  localparam logic [CNT_W-1:0] ONE_L = CNT_W'(1);

  state_t st, st_nxt;

  logic [CNT_W-1:0]     cnt;
  logic [WIDTH-1:0]     a_r, b_r, a_in, b_in;
  logic [ACC_W-1:0]     acc, acc_nxt, row_sh;
  logic [WIDTH+BPC-1:0] row;
  logic [2*WIDTH-1:0]   res;
  logic                 accept;

  assign in_ready = (st == IDLE);
  assign accept   = in_valid && in_ready;

`ifdef MULT_SEQ_SIGNED_EN
  // Work on magnitudes; -2^(W-1) negates to itself, which read unsigned is
  // exactly its magnitude, so the most-negative corner needs no special case.
  logic neg_in, neg_r;
  assign a_in   = (is_signed && a[WIDTH-1]) ? -a : a;
  assign b_in   = (is_signed && b[WIDTH-1]) ? -b : b;
  assign neg_in = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
  assign res    = neg_r ? -acc_nxt[2*WIDTH-1:0] : acc_nxt[2*WIDTH-1:0];
`else
  assign a_in = a;
  assign b_in = b;
  assign res  = acc_nxt[2*WIDTH-1:0];
`endif

  mult_pp_row #(.WIDTH(WIDTH), .BPC(BPC)) u_row (
    .a     (a_r),
    .slice (b_r[BPC-1:0]),
    .row   (row)
  );

  // Iteration k = CYCLES-cnt weights this row by 2^(k*BPC).
  assign row_sh  = ACC_W'(row) << (int'(CYC_L - cnt) * BPC);
  assign acc_nxt = acc + row_sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= IDLE;
    else     st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      IDLE:    if (in_valid)      st_nxt = BUSY;
      BUSY:    if (cnt == ONE_L)  st_nxt = DONE;
      DONE:    if (out_ready)     st_nxt = IDLE;
      default:                    st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      a_r       <= '0;
      b_r       <= '0;
      acc       <= '0;
      product   <= '0;
      out_valid <= 1'b0;
`ifdef MULT_SEQ_SIGNED_EN
      neg_r     <= 1'b0;
`endif
    end else if (accept) begin
      a_r <= a_in;
      b_r <= b_in;
      cnt <= CYC_L;
      acc <= '0;
`ifdef MULT_SEQ_SIGNED_EN
      neg_r <= neg_in;
`endif
    end else if (st == BUSY) begin
      acc <= acc_nxt;
      b_r <= b_r >> BPC;
      cnt <= cnt - ONE_L;
      if (cnt == ONE_L) begin
        product   <= res;
        out_valid <= 1'b1;
      end
    end else if (st == DONE && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
